// File: rtl/eth_rst_seq_ctrl.sv
// rtl/eth_rst_seq_ctrl.sv - Ethernet-RX / GTP-TX reset sequencer in the eth_gtx_clk domain.
// Optional link watchdog in RUN is enabled by defining RST_SEQ_LINK_WDOG_EN.
module eth_rst_seq_ctrl #(
   parameter int unsigned PHY_RST_CYC   = 64,
   parameter int unsigned PHY_WAIT_CYC  = 1024,
   parameter int unsigned STAGE_GAP_CYC = 16,
   parameter int unsigned GTP_TMO_CYC   = 65535,
   parameter int unsigned MAX_RETRY     = 3,
   parameter int unsigned CNT_W         = 17,
   parameter int unsigned WDOG_CYC      = 125000
) (
   input  logic       eth_gtx_clk,
   input  logic       g_resetn,
   input  logic       dcm_locked,
   input  logic       soft_rst_req,
   input  logic       gtp_reset_done,
   input  logic       link_up,
   output logic       phy_resetn,
   output logic       mac_resetn,
   output logic       fifo_resetn,
   output logic       gtp_reset,
   output logic [2:0] seq_state,
   output logic       seq_done,
   output logic       seq_fail,
   output logic [1:0] retry_cnt
);

   if (MAX_RETRY < 1 || MAX_RETRY > 3) begin : g_bad_max_retry
      $error("eth_rst_seq_ctrl: MAX_RETRY must be in 1..3");
   end

   typedef enum logic [2:0] {
      S_WAIT_LOCK = 3'd0,
      S_PHY_RST   = 3'd1,
      S_PHY_WAIT  = 3'd2,
      S_MAC_REL   = 3'd3,
      S_FIFO_REL  = 3'd4,
      S_GTP_REL   = 3'd5,
      S_RUN       = 3'd6,
      S_FAIL      = 3'd7
   } state_e;

   localparam logic [CNT_W-1:0] PHY_RST_LAST  = CNT_W'(PHY_RST_CYC - 1);
   localparam logic [CNT_W-1:0] PHY_WAIT_LAST = CNT_W'(PHY_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST      = CNT_W'(STAGE_GAP_CYC - 1);
   localparam logic [CNT_W-1:0] TMO_LAST      = CNT_W'(GTP_TMO_CYC - 1);
   localparam logic [1:0]       RETRY_MAX     = 2'(MAX_RETRY);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       retry_q, retry_d;
   logic             lock_s1_q, lock_sync_q;
   logic             done_s1_q, done_sync_q;
   logic             phy_rstn_q, mac_rstn_q, fifo_rstn_q, gtp_rst_q;
   logic             seq_done_q, seq_fail_q;
   logic             enter, tmo, timed, wdog_hit;

`ifdef RST_SEQ_LINK_WDOG_EN
   localparam int unsigned      WD_W    = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WDOG_CYC - 1);
   logic [WD_W-1:0] wdog_q, wdog_d;

   assign wdog_hit = (state_q == S_RUN) && !link_up && (wdog_q == WD_LAST);
   // Counts only while staying in RUN with the link down; anything else restarts it.
   assign wdog_d   = (state_q == S_RUN && state_d == S_RUN && !link_up) ? wdog_q + WD_W'(1) : '0;

   always_ff @(posedge eth_gtx_clk or negedge g_resetn) begin
      if (!g_resetn) wdog_q <= '0;
      else           wdog_q <= wdog_d;
   end
`else
   logic unused_wdog;
   assign unused_wdog = link_up ^ WDOG_CYC[0];
   assign wdog_hit    = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      enter   = 1'b0;
      tmo     = 1'b0;
      timed   = state_q inside {S_PHY_RST, S_PHY_WAIT, S_MAC_REL, S_FIFO_REL, S_GTP_REL};
      if (state_q != S_WAIT_LOCK && !lock_sync_q) begin
         state_d = S_WAIT_LOCK;
         retry_d = 2'd0;
         enter   = 1'b1;
      end else if (state_q != S_WAIT_LOCK && soft_rst_req) begin
         state_d = S_PHY_RST;
         retry_d = 2'd0;
         enter   = 1'b1;
      end else begin
         case (state_q)
            S_WAIT_LOCK: if (lock_sync_q) begin state_d = S_PHY_RST; enter = 1'b1; end
            S_PHY_RST:   if (cnt_q == PHY_RST_LAST) begin state_d = S_PHY_WAIT; enter = 1'b1; end
            S_PHY_WAIT:  if (cnt_q == PHY_WAIT_LAST) begin state_d = S_MAC_REL; enter = 1'b1; end
            S_MAC_REL:   if (cnt_q == GAP_LAST) begin state_d = S_FIFO_REL; enter = 1'b1; end
            S_FIFO_REL:  if (cnt_q == GAP_LAST) begin state_d = S_GTP_REL; enter = 1'b1; end
            S_GTP_REL: begin
               if (done_sync_q) begin
                  state_d = S_RUN;
                  enter   = 1'b1;
               end else if (cnt_q == TMO_LAST) begin
                  tmo = 1'b1;
               end
            end
            S_RUN: begin
               if (!done_sync_q) begin
                  tmo = 1'b1;
               end else if (wdog_hit) begin
                  state_d = S_PHY_RST;
                  enter   = 1'b1;
               end
            end
            default: ;
         endcase
         if (tmo) begin
            enter = 1'b1;
            if (retry_q < RETRY_MAX) begin
               retry_d = retry_q + 2'd1;
               state_d = S_PHY_RST;
            end else begin
               state_d = S_FAIL;
            end
         end
      end
      cnt_d = enter ? '0 : (timed ? cnt_q + CNT_W'(1) : cnt_q);
   end

   // Reset pins are decoded from the next state so every release lands on the state edge.
   always_ff @(posedge eth_gtx_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         lock_s1_q   <= 1'b0;
         lock_sync_q <= 1'b0;
         done_s1_q   <= 1'b0;
         done_sync_q <= 1'b0;
         state_q     <= S_WAIT_LOCK;
         cnt_q       <= '0;
         retry_q     <= 2'd0;
         phy_rstn_q  <= 1'b0;
         mac_rstn_q  <= 1'b0;
         fifo_rstn_q <= 1'b0;
         gtp_rst_q   <= 1'b1;
         seq_done_q  <= 1'b0;
         seq_fail_q  <= 1'b0;
      end else begin
         lock_s1_q   <= dcm_locked;
         lock_sync_q <= lock_s1_q;
         done_s1_q   <= gtp_reset_done;
         done_sync_q <= done_s1_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         phy_rstn_q  <= !(state_d inside {S_WAIT_LOCK, S_PHY_RST, S_FAIL});
         mac_rstn_q  <= state_d inside {S_MAC_REL, S_FIFO_REL, S_GTP_REL, S_RUN};
         fifo_rstn_q <= state_d inside {S_FIFO_REL, S_GTP_REL, S_RUN};
         gtp_rst_q   <= !(state_d inside {S_GTP_REL, S_RUN});
         seq_done_q  <= (state_d == S_RUN);
         seq_fail_q  <= (state_d == S_FAIL);
      end
   end

   assign phy_resetn  = phy_rstn_q;
   assign mac_resetn  = mac_rstn_q;
   assign fifo_resetn = fifo_rstn_q;
   assign gtp_reset   = gtp_rst_q;
   assign seq_state   = state_q;
   assign seq_done    = seq_done_q;
   assign seq_fail    = seq_fail_q;
   assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_eth_rst_seq_ctrl.sv
// tb/tb_eth_rst_seq_ctrl.sv - scoreboard bench for eth_rst_seq_ctrl (small timing parameters).
module tb_eth_rst_seq_ctrl;

   logic       clk = 1'b0;
   logic       g_resetn, dcm_locked, soft_rst_req, gtp_reset_done, link_up;
   logic       phy_resetn, mac_resetn, fifo_resetn, gtp_reset, seq_done, seq_fail;
   logic [2:0] seq_state;
   logic [1:0] retry_cnt;

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int         at;
      logic [2:0] st;
      logic [1:0] rc;
   } exp_t;
   exp_t exp_q[$];

   eth_rst_seq_ctrl #(
      .PHY_RST_CYC(4), .PHY_WAIT_CYC(8), .STAGE_GAP_CYC(2), .GTP_TMO_CYC(16),
      .MAX_RETRY(2), .CNT_W(17), .WDOG_CYC(10)
   ) dut (
      .eth_gtx_clk(clk), .g_resetn(g_resetn), .dcm_locked(dcm_locked),
      .soft_rst_req(soft_rst_req), .gtp_reset_done(gtp_reset_done), .link_up(link_up),
      .phy_resetn(phy_resetn), .mac_resetn(mac_resetn), .fifo_resetn(fifo_resetn),
      .gtp_reset(gtp_reset), .seq_state(seq_state), .seq_done(seq_done),
      .seq_fail(seq_fail), .retry_cnt(retry_cnt)
   );

   always #4 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // {phy_resetn, mac_resetn, fifo_resetn, gtp_reset, seq_done, seq_fail} per state
   function automatic logic [5:0] outs_of(input logic [2:0] s);
      case (s)
         3'd0:    return 6'b000100;
         3'd1:    return 6'b000100;
         3'd2:    return 6'b100100;
         3'd3:    return 6'b110100;
         3'd4:    return 6'b111100;
         3'd5:    return 6'b111000;
         3'd6:    return 6'b111010;
         default: return 6'b000101;
      endcase
   endfunction

   task automatic expect_at(input int at, input logic [2:0] st, input logic [1:0] rc);
      exp_t e;
      e.at = at; e.st = st; e.rc = rc;
      exp_q.push_back(e);
   endtask

   // One pass PHY_RST -> GTP_REL starting with PHY_RST on edge t.
   task automatic seq_pass(input int t, input logic [1:0] rc);
      expect_at(t,      3'd1, rc);
      expect_at(t + 4,  3'd2, rc);
      expect_at(t + 12, 3'd3, rc);
      expect_at(t + 14, 3'd4, rc);
      expect_at(t + 16, 3'd5, rc);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) tick(1);
   endtask

   logic [10:0] prev_snap = 'x;
   always @(negedge clk) begin
      logic [10:0] snap, want;
      exp_t e;
      snap = {seq_state, phy_resetn, mac_resetn, fifo_resetn, gtp_reset, seq_done, seq_fail, retry_cnt};
      if (snap !== prev_snap) begin
         prev_snap = snap;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_change cyc=%0d got state=%0d outs=%b retry=%0d, required no change",
                     cyc, seq_state, snap[7:2], retry_cnt);
         end else begin
            e = exp_q.pop_front();
            want = {e.st, outs_of(e.st), e.rc};
            if (snap !== want || (e.at >= 0 && cyc != e.at)) begin
               n_err++;
               $display("FAIL step_%0d cyc=%0d state=%0d outs=%b retry=%0d, required cyc=%0d state=%0d outs=%b retry=%0d",
                        n_vec, cyc, seq_state, snap[7:2], retry_cnt, e.at, e.st, outs_of(e.st), e.rc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL sim_time_limit cyc=%0d, required completion", cyc);
      $fatal(1, "time limit");
   end

   initial begin
      int t, tb;
      g_resetn = 1'b0; dcm_locked = 1'b0; soft_rst_req = 1'b0;
      gtp_reset_done = 1'b0; link_up = 1'b1;
      expect_at(-1, 3'd0, 2'd0);
      tick(3);

      // power-up
      t = cyc; g_resetn = 1'b1; dcm_locked = 1'b1;
      seq_pass(t + 3, 2'd0);
      expect_at(t + 23, 3'd6, 2'd0);
      wait_to(t + 20); gtp_reset_done = 1'b1;
      wait_to(t + 26);

      // soft request in RUN, then GTP never completes: two retries and FAIL
      t = cyc; soft_rst_req = 1'b1; gtp_reset_done = 1'b0;
      seq_pass(t + 1, 2'd0);
      seq_pass(t + 33, 2'd1);
      seq_pass(t + 65, 2'd2);
      expect_at(t + 97, 3'd7, 2'd2);
      tick(1); soft_rst_req = 1'b0;
      wait_to(t + 100);

      // soft request in FAIL; later soft collides with a timeout at retry 1
      t = cyc; soft_rst_req = 1'b1; tb = t + 1;
      seq_pass(tb, 2'd0);
      seq_pass(tb + 32, 2'd1);
      seq_pass(tb + 64, 2'd0);
      seq_pass(tb + 96, 2'd1);
      expect_at(tb + 113, 3'd0, 2'd0);
      tick(1); soft_rst_req = 1'b0;
      wait_to(tb + 63); soft_rst_req = 1'b1;
      tick(1); soft_rst_req = 1'b0;

      // lock loss during FIFO_REL, then soft request in WAIT_LOCK is ignored
      wait_to(tb + 110); dcm_locked = 1'b0;
      wait_to(tb + 116); soft_rst_req = 1'b1;
      tick(1); soft_rst_req = 1'b0;
      wait_to(tb + 122);

      // relock replays the full sequence
      t = cyc; dcm_locked = 1'b1;
      seq_pass(t + 3, 2'd0);
      expect_at(t + 23, 3'd6, 2'd0);
      wait_to(t + 20); gtp_reset_done = 1'b1;
      wait_to(t + 26);

      // gtp_reset_done drops in RUN: counted as a timeout
      t = cyc; gtp_reset_done = 1'b0;
      seq_pass(t + 3, 2'd1);
      expect_at(t + 20, 3'd6, 2'd1);
      wait_to(t + 6); gtp_reset_done = 1'b1;
      wait_to(t + 23);

`ifdef RST_SEQ_LINK_WDOG_EN
      t = cyc; link_up = 1'b0;
      wait_to(t + 9); link_up = 1'b1;
      wait_to(t + 12);
      t = cyc; link_up = 1'b0;
      seq_pass(t + 10, 2'd1);
      expect_at(t + 27, 3'd6, 2'd1);
      wait_to(t + 10); link_up = 1'b1;
      wait_to(t + 30);
`endif

      tick(3);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL pending_events got %0d outstanding, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
